// File: rtl/wb_arbiter.sv
// Write-back arbiter: two one-entry holding registers feeding the single
// register-file write port with round-robin grants and a decode pending check.
module wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s0_valid,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              w_req,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] q1_addr,
  output logic              q1_pending,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              q2_pending
);

  logic              h0_vld_p0, h1_vld_p0;
  logic [ADDR_W-1:0] h0_addr_p0, h1_addr_p0;
  logic [DATA_W-1:0] h0_data_p0, h1_data_p0;
  logic              last_grant;
  logic              cand0;
  logic              grant0, grant1;
  logic              xfer0, xfer1;

  function automatic logic pending_hit(input logic [ADDR_W-1:0] q);
    return (q != '0) &&
           ((h0_vld_p0 && (h0_addr_p0 == q)) ||
            (h1_vld_p0 && (h1_addr_p0 == q)) ||
            (w_req && (w_addr == q)));
  endfunction

  // Arbitration over held entries; last_grant==1 means source 0 wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    cand0  = h0_vld_p0 && !flush;
    if (cand0 && h1_vld_p0) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = cand0;
      grant1 = h1_vld_p0;
    end
  end

  assign s0_ready   = !rst && !flush && (!h0_vld_p0 || grant0);
  assign s1_ready   = !rst && (!h1_vld_p0 || grant1);
  assign xfer0      = s0_valid && s0_ready;
  assign xfer1      = s1_valid && s1_ready;
  assign q1_pending = !rst && pending_hit(q1_addr);
  assign q2_pending = !rst && pending_hit(q2_addr);

  // Stage p0: holding registers (valid bits reset, payload free-running)
  always_ff @(posedge clk) begin
    if (rst) begin
      h0_vld_p0 <= 1'b0;
      h1_vld_p0 <= 1'b0;
    end else begin
      if (flush)
        h0_vld_p0 <= 1'b0;
      else if (xfer0 && (s0_addr != '0))
        h0_vld_p0 <= 1'b1;
      else if (grant0)
        h0_vld_p0 <= 1'b0;

      if (xfer1 && (s1_addr != '0))
        h1_vld_p0 <= 1'b1;
      else if (grant1)
        h1_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer0 && (s0_addr != '0)) begin
      h0_addr_p0 <= s0_addr;
      h0_data_p0 <= s0_data;
    end
    if (xfer1 && (s1_addr != '0)) begin
      h1_addr_p0 <= s1_addr;
      h1_data_p0 <= s1_data;
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      w_req      <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      last_grant <= 1'b1;
    end else if (grant0) begin
      w_req      <= 1'b1;
      w_addr     <= h0_addr_p0;
      w_data     <= h0_data_p0;
      last_grant <= 1'b0;
    end else if (grant1) begin
      w_req      <= 1'b1;
      w_addr     <= h1_addr_p0;
      w_data     <= h1_data_p0;
      last_grant <= 1'b1;
    end else begin
      w_req      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios plus random traffic
// against a queue-based behavioural model of the write-back arbiter.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [4:0]  s0_addr, s1_addr, q1_addr, q2_addr, w_addr;
  logic [31:0] s0_data, s1_data, w_data;
  logic        w_req, q1_pending, q2_pending;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        req;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Behavioural model: one slot per source, round-robin pointer, write port.
  bit          m_full[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_last = 1;
  bit          m_wreq = 0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  wb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
    .q1_addr(q1_addr), .q1_pending(q1_pending),
    .q2_addr(q2_addr), .q2_pending(q2_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_pend(input bit r, input logic [4:0] q);
    if (r || q == 5'd0) return 1'b0;
    return (m_full[0] && m_addr[0] == q) || (m_full[1] && m_addr[1] == q) ||
           (m_wreq && m_waddr == q);
  endfunction

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic step(input bit r, input bit f,
                      input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] qa, input logic [4:0] qb);
    int  g;
    bit  rdy0, rdy1;
    wr_t e;
    rst = r; flush = f;
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
    q1_addr = qa; q2_addr = qb;
    #1;
    g = -1;
    if (m_full[0] && !f && m_full[1]) g = (m_last == 0) ? 1 : 0;
    else if (m_full[0] && !f)         g = 0;
    else if (m_full[1])               g = 1;
    rdy0 = !r && !f && (!m_full[0] || g == 0);
    rdy1 = !r && (!m_full[1] || g == 1);
    check("s0_ready", {31'd0, s0_ready}, {31'd0, rdy0});
    check("s1_ready", {31'd0, s1_ready}, {31'd0, rdy1});
    check("q1_pending", {31'd0, q1_pending}, {31'd0, exp_pend(r, qa)});
    check("q2_pending", {31'd0, q2_pending}, {31'd0, exp_pend(r, qb)});
    @(posedge clk);
    if (r) begin
      m_full[0] = 0; m_full[1] = 0; m_last = 1;
      m_wreq = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      if (g >= 0) begin
        m_wreq = 1; m_waddr = m_addr[g]; m_wdata = m_data[g];
        m_full[g] = 0; m_last = g;
      end else begin
        m_wreq = 0;
      end
      if (v0 && rdy0 && a0 != 5'd0) begin m_full[0] = 1; m_addr[0] = a0; m_data[0] = d0; end
      if (f) m_full[0] = 0;
      if (v1 && rdy1 && a1 != 5'd0) begin m_full[1] = 1; m_addr[1] = a1; m_data[1] = d1; end
    end
    e.req = m_wreq; e.addr = m_waddr; e.data = m_wdata;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [4:0] qa);
    for (int i = 0; i < n; i++) step(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, qa, 5'd0);
  endtask

  // Monitor: every edge the write port must match the next scoreboard entry.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got write-port cycle with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("w_req", {31'd0, w_req}, {31'd0, e.req});
        check("w_addr", {27'd0, w_addr}, {27'd0, e.addr});
        check("w_data", w_data, e.data);
      end
    end
  end

  initial begin
    m_full[0] = 0; m_full[1] = 0;
    m_addr[0] = '0; m_addr[1] = '0;
    m_data[0] = '0; m_data[1] = '0;

    step(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1, 0, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2, 5'd3, 5'd4);

    // single write with pending tracking
    step(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(3, 5'd5);

    // tie after reset-equivalent pointer: source 0 first
    step(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(0, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 5'd1, 5'd2);
    idle(3, 5'd2);

    // streaming alternation
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, 5'(i % 8 + 10), 32'(32'h100 + i), 1, 5'(i % 8 + 20), 32'(32'h200 + i),
           5'(i % 8 + 10), 5'(i % 8 + 20));
    idle(3, 5'd0);

    // x0 drop
    step(0, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle(2, 5'd0);

    // flush of a held source-0 entry while h1 holds reg 8
    step(0, 0, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 5'd7, 5'd8);
    step(0, 1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd8);
    idle(3, 5'd7);

    // reset mid-operation with both holdings full
    step(0, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 5'd3, 5'd4);
    step(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd3, 5'd4);
    step(0, 0, 1, 5'd6, 32'h66, 1, 5'd9, 32'h99, 5'd3, 5'd4);
    idle(3, 5'd6);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(4, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
